// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, the packed
// control word carried from decode to execute, and its width.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Field order is the bit order of ex_ctrl, jr at the MSB.
    typedef struct packed {
        logic       jr;
        logic       jmp;
        logic       jal;
        logic       branch;
        logic       nbranch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       i_format;
        logic       sftmd;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: reads_rt = 1'b1;
            default:                         reads_rt = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ctrl_dec.sv
// Purely combinational instruction decoder: control word, destination
// register and extended immediate for one 32-bit instruction.
module id_ctrl_dec
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] imm
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_j;
    logic       is_jal;
    logic       is_beq;
    logic       is_bne;
    logic       is_i;
    logic       is_ill;
    logic       is_jr;
    logic       is_shift;
    logic       legal;

    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign is_jr = is_r && (fn == FN_JR);
    assign legal = !is_ill;

    // Opcode classification; anything unrecognised is illegal.
    always_comb begin
        is_r   = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_j   = 1'b0;
        is_jal = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_i   = 1'b0;
        is_ill = 1'b0;
        case (op)
            OP_RTYPE: is_r   = 1'b1;
            OP_LW:    is_lw  = 1'b1;
            OP_SW:    is_sw  = 1'b1;
            OP_J:     is_j   = 1'b1;
            OP_JAL:   is_jal = 1'b1;
            OP_BEQ:   is_beq = 1'b1;
            OP_BNE:   is_bne = 1'b1;
            default: begin
                if (op[5:3] == 3'b001) begin
                    is_i = 1'b1;
                end else begin
                    is_ill = 1'b1;
                end
            end
        endcase
    end

    // Shift-family funct detection.
    always_comb begin
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: is_shift = 1'b1;
            default:                                          is_shift = 1'b0;
        endcase
    end

    // Control word; side-effecting and flow-changing bits are gated by legality.
    always_comb begin
        ctrl            = ctrl_t'({CTRL_W{1'b0}});
        ctrl.jr         = is_jr && legal;
        ctrl.jmp        = is_j && legal;
        ctrl.jal        = is_jal && legal;
        ctrl.branch     = is_beq && legal;
        ctrl.nbranch    = is_bne && legal;
        ctrl.reg_dst    = is_r;
        ctrl.mem_to_reg = is_lw;
        ctrl.reg_write  = (is_r || is_lw || is_jal || is_i) && !is_jr && legal;
        ctrl.mem_write  = is_sw && legal;
        ctrl.alu_src    = is_i || is_lw || is_sw;
        ctrl.i_format   = is_i;
        ctrl.sftmd      = is_r && is_shift;
        ctrl.alu_op     = {is_r || is_i, is_beq || is_bne};
        ctrl.illegal    = is_ill;
    end

    // Destination register select: link register for jal, rd for R-type.
    always_comb begin
        if (is_jal) begin
            wr_addr = 5'd31;
        end else if (is_r) begin
            wr_addr = instr[15:11];
        end else begin
            wr_addr = instr[20:16];
        end
    end

    // Immediate extension: logical ops zero-extend, lui shifts up then sign-extends.
    always_comb begin
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: imm = XLEN'(instr[15:0]);
            OP_LUI:                   imm = XLEN'($signed({instr[15:0], 16'h0000}));
            default:                  imm = XLEN'($signed(instr[15:0]));
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Decode pipeline stage: registered decode output with valid/ready handshake,
// flush, and optional load-use interlock enabled by ID_STAGE_LOADUSE_EN.
module id_stage
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_ready,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wr_addr,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_t           dec_ctrl;
    logic [4:0]      dec_wr_addr;
    logic [XLEN-1:0] dec_imm;
    logic            hazard;
    logic            slot_free;
    logic            accept;

    id_ctrl_dec #(
        .XLEN    (XLEN)
    ) u_dec (
        .instr   (if_instr),
        .ctrl    (dec_ctrl),
        .wr_addr (dec_wr_addr),
        .imm     (dec_imm)
    );

    assign slot_free = !ex_valid || ex_ready;
    assign if_ready  = slot_free && !hazard && !flush;
    assign accept    = if_valid && if_ready;

`ifdef ID_STAGE_LOADUSE_EN
    ctrl_t held_ctrl;
    logic  rs_hit;
    logic  rt_hit;

    assign held_ctrl = ctrl_t'(ex_ctrl);
    assign rs_hit    = (ex_wr_addr == if_instr[25:21]);
    assign rt_hit    = reads_rt(if_instr[31:26]) && (ex_wr_addr == if_instr[20:16]);
    assign hazard    = if_valid && ex_valid && held_ctrl.mem_to_reg &&
                       (ex_wr_addr != 5'd0) && (rs_hit || rt_hit);

    // Bubble counter, saturating; a flush cancels the stall it would count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (hazard && ex_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`else
    assign hazard    = 1'b0;
    assign stall_cnt = {CNT_W{1'b0}};
`endif

    // Valid bit: flush kills, acceptance fills, a consume or bubble empties.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (slot_free) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid <= ex_valid;
        end
    end

    // Payload register, loaded only on acceptance so a stalled slot stays stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_ctrl    <= {CTRL_W{1'b0}};
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_wr_addr <= 5'd0;
            ex_opcode  <= 6'd0;
            ex_funct   <= 6'd0;
            ex_imm     <= {XLEN{1'b0}};
            ex_pc      <= {XLEN{1'b0}};
        end else if (accept) begin
            ex_ctrl    <= dec_ctrl;
            ex_rs      <= if_instr[25:21];
            ex_rt      <= if_instr[20:16];
            ex_wr_addr <= dec_wr_addr;
            ex_opcode  <= if_instr[31:26];
            ex_funct   <= if_instr[5:0];
            ex_imm     <= dec_imm;
            ex_pc      <= if_pc;
        end else begin
            ex_ctrl    <= ex_ctrl;
            ex_rs      <= ex_rs;
            ex_rt      <= ex_rt;
            ex_wr_addr <= ex_wr_addr;
            ex_opcode  <= ex_opcode;
            ex_funct   <= ex_funct;
            ex_imm     <= ex_imm;
            ex_pc      <= ex_pc;
        end
    end

endmodule
